// File: rtl/hm_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the 64-bit TRN transmit port between three TLP sources.
// Define HM_TX_ARB_STATS_EN to add per-source packet counters and an abort counter.
module hm_tx_arbiter #(
   parameter int unsigned PRIO_CPL    = 1,
   parameter int unsigned WDOG_CYCLES = 4096
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   input  logic [191:0] src_td,
   input  logic [23:0]  src_trem_n,
   input  logic [2:0]   src_tsof_n,
   input  logic [2:0]   src_teof_n,
   input  logic [2:0]   src_tsrc_rdy_n,
   output logic [2:0]   src_tdst_rdy_n,
   output logic [2:0]   src_abort,
   output logic [63:0]  trn_td,
   output logic [7:0]   trn_trem_n,
   output logic         trn_tsof_n,
   output logic         trn_teof_n,
   output logic         trn_tsrc_rdy_n,
   output logic         trn_tsrc_dsc_n,
   input  logic         trn_tdst_rdy_n,
   input  logic [5:0]   trn_tbuf_av,
`ifdef HM_TX_ARB_STATS_EN
   output logic [47:0]  stat_pkt,
   output logic [7:0]   stat_abort,
`endif
   input  logic         trn_lnk_up_n
);

   localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
   localparam logic [WdogW-1:0] WdogLast = WdogW'((WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StXfer, StDsc} state_e;

   state_e           state_q;
   logic [1:0]       g_q;
   logic [1:0]       rr_q;
   logic [WdogW-1:0] wdog_q;
   logic [2:0]       abort_q;

   logic [2:0]  elig;
   logic [1:0]  win;
   logic [1:0]  rr_p1;
   logic [1:0]  rr_p2;
   logic [1:0]  g_next;
   logic [63:0] g_td;
   logic [7:0]  g_trem_n;
   logic        g_vld;
   logic        beat;
   logic        eof_beat;
   logic        abort_evt;

   function automatic logic [1:0] rr_inc(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   // Class mapping: completions use bit2, non-posted reads bit0, posted writes bit1.
   assign elig[0] = ~src_tsrc_rdy_n[0] & ~src_tsof_n[0] & ~trn_lnk_up_n & trn_tbuf_av[2];
   assign elig[1] = ~src_tsrc_rdy_n[1] & ~src_tsof_n[1] & ~trn_lnk_up_n & trn_tbuf_av[0];
   assign elig[2] = ~src_tsrc_rdy_n[2] & ~src_tsof_n[2] & ~trn_lnk_up_n & trn_tbuf_av[1];

   assign rr_p1  = rr_inc(rr_q);
   assign rr_p2  = rr_inc(rr_p1);
   assign g_next = rr_inc(g_q);

   always_comb begin
      win = rr_q;
      if ((PRIO_CPL != 0) && elig[0]) begin
         win = 2'd0;
      end else if (elig[rr_q]) begin
         win = rr_q;
      end else if (elig[rr_p1]) begin
         win = rr_p1;
      end else begin
         win = rr_p2;
      end
   end

   always_comb begin
      unique case (g_q)
         2'd1:    begin g_td = src_td[127:64];  g_trem_n = src_trem_n[15:8];  end
         2'd2:    begin g_td = src_td[191:128]; g_trem_n = src_trem_n[23:16]; end
         default: begin g_td = src_td[63:0];    g_trem_n = src_trem_n[7:0];   end
      endcase
   end

   assign g_vld     = ~src_tsrc_rdy_n[g_q];
   assign beat      = (state_q == StXfer) & ~trn_lnk_up_n & g_vld & ~trn_tdst_rdy_n;
   assign eof_beat  = beat & ~src_teof_n[g_q];
   assign abort_evt = ((state_q == StXfer) & trn_lnk_up_n) |
                      ((state_q == StDsc) & (~trn_tdst_rdy_n | trn_lnk_up_n));

   // Outputs are forced to idle values while reset is held so a packet stops immediately.
   always_comb begin
      trn_td         = '0;
      trn_trem_n     = '0;
      trn_tsof_n     = 1'b1;
      trn_teof_n     = 1'b1;
      trn_tsrc_rdy_n = 1'b1;
      trn_tsrc_dsc_n = 1'b1;
      src_tdst_rdy_n = 3'b111;
      if (!sys_rst) begin
         case (state_q)
            StXfer: begin
               if (!trn_lnk_up_n) begin
                  trn_td              = g_td;
                  trn_trem_n          = g_trem_n;
                  trn_tsof_n          = src_tsof_n[g_q];
                  trn_teof_n          = src_teof_n[g_q];
                  trn_tsrc_rdy_n      = src_tsrc_rdy_n[g_q];
                  src_tdst_rdy_n[g_q] = trn_tdst_rdy_n;
               end
            end
            StDsc: begin
               trn_td         = g_td;
               trn_trem_n     = g_trem_n;
               trn_teof_n     = 1'b0;
               trn_tsrc_rdy_n = 1'b0;
               trn_tsrc_dsc_n = 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign src_abort = abort_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= StIdle;
         g_q     <= 2'd0;
         rr_q    <= 2'd0;
         wdog_q  <= '0;
         abort_q <= 3'b000;
      end else begin
         abort_q <= 3'b000;
         case (state_q)
            StIdle: begin
               if (|elig) begin
                  g_q     <= win;
                  wdog_q  <= '0;
                  state_q <= StXfer;
               end
            end
            StXfer: begin
               if (abort_evt) begin
                  abort_q <= 3'b001 << g_q;
                  rr_q    <= g_next;
                  state_q <= StIdle;
               end else if (beat) begin
                  wdog_q <= '0;
                  if (eof_beat) begin
                     rr_q    <= g_next;
                     state_q <= StIdle;
                  end
               end else if (WDOG_CYCLES != 0) begin
                  if (wdog_q == WdogLast) begin
                     state_q <= StDsc;
                  end else begin
                     wdog_q <= wdog_q + 1'b1;
                  end
               end
            end
            StDsc: begin
               if (abort_evt) begin
                  abort_q <= 3'b001 << g_q;
                  rr_q    <= g_next;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef HM_TX_ARB_STATS_EN
   logic [47:0] pkt_q;
   logic [7:0]  abrt_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pkt_q  <= '0;
         abrt_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (eof_beat && (g_q == 2'(i))) begin
               pkt_q[16*i +: 16] <= pkt_q[16*i +: 16] + 16'd1;
            end
         end
         if (abort_evt && (abrt_q != 8'hff)) begin
            abrt_q <= abrt_q + 8'd1;
         end
      end
   end

   assign stat_pkt   = pkt_q;
   assign stat_abort = abrt_q;
`endif

endmodule

// File: tb/tb_hm_tx_arbiter.sv
// Bench for hm_tx_arbiter: directed scenarios plus a randomized run against a packet-level model.
module tb_hm_tx_arbiter;

   localparam int unsigned TbPrio = 1;

   logic         sys_clk = 1'b0;
   logic         sys_rst = 1'b1;
   logic [191:0] src_td = '0;
   logic [23:0]  src_trem_n = '0;
   logic [2:0]   src_tsof_n = 3'b111;
   logic [2:0]   src_teof_n = 3'b111;
   logic [2:0]   src_tsrc_rdy_n = 3'b111;
   logic [2:0]   src_tdst_rdy_n;
   logic [2:0]   src_abort;
   logic [63:0]  trn_td;
   logic [7:0]   trn_trem_n;
   logic         trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
   logic         trn_tdst_rdy_n = 1'b0;
   logic [5:0]   trn_tbuf_av = '0;
   logic         trn_lnk_up_n = 1'b1;
`ifdef HM_TX_ARB_STATS_EN
   logic [47:0]  stat_pkt;
   logic [7:0]   stat_abort;
`endif

   always #5 sys_clk = ~sys_clk;

   hm_tx_arbiter #(.PRIO_CPL(TbPrio), .WDOG_CYCLES(8)) dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .src_td         (src_td),
      .src_trem_n     (src_trem_n),
      .src_tsof_n     (src_tsof_n),
      .src_teof_n     (src_teof_n),
      .src_tsrc_rdy_n (src_tsrc_rdy_n),
      .src_tdst_rdy_n (src_tdst_rdy_n),
      .src_abort      (src_abort),
      .trn_td         (trn_td),
      .trn_trem_n     (trn_trem_n),
      .trn_tsof_n     (trn_tsof_n),
      .trn_teof_n     (trn_teof_n),
      .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
      .trn_tsrc_dsc_n (trn_tsrc_dsc_n),
      .trn_tdst_rdy_n (trn_tdst_rdy_n),
      .trn_tbuf_av    (trn_tbuf_av),
`ifdef HM_TX_ARB_STATS_EN
      .stat_pkt       (stat_pkt),
      .stat_abort     (stat_abort),
`endif
      .trn_lnk_up_n   (trn_lnk_up_n)
   );

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   // Knobs applied to the DUT just after each rising edge.
   logic       sink_n = 1'b0;
   logic       lnk_n = 1'b1;
   logic [5:0] tbuf = '0;

   // Per-source beat store: {sof, eof, data}.
   logic [65:0] mem [3][64];
   int          rd [3];
   int          wr [3];
   int          gag_at [3];
   logic [2:0]  acc = '0;
   int          exp_pkt [3];
   int          exp_abort = 0;
   int          sof_src [$];
   int          sof_cyc [$];

   // Packet-level reference model for the randomized run.
   bit sb_en = 1'b0;
   bit m_busy = 1'b0;
   int m_g = 0;
   int m_rr = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic bit src_valid(input int i);
      return (rd[i] < wr[i]) && !((gag_at[i] >= 0) && (rd[i] >= gag_at[i]));
   endfunction

   task automatic push_beat(input int s, input bit sof, input bit eof, input logic [63:0] d);
      if (rd[s] == wr[s]) begin
         rd[s] = 0;
         wr[s] = 0;
      end
      mem[s][wr[s]] = {sof, eof, d};
      wr[s]++;
   endtask

   task automatic push_pkt(input int s, input int n, input logic [63:0] base);
      for (int k = 0; k < n; k++) push_beat(s, k == 0, k == n - 1, base + 64'(k));
   endtask

   task automatic flush(input int s);
      rd[s] = 0;
      wr[s] = 0;
      gag_at[s] = -1;
      acc[s] = 1'b0;
   endtask

   task automatic drive();
      for (int i = 0; i < 3; i++) begin
         logic [65:0] b;
         bit v;
         v = src_valid(i);
         b = v ? mem[i][rd[i]] : '0;
         src_td[64*i +: 64] = b[63:0];
         src_tsof_n[i]      = !(v && b[65]);
         src_teof_n[i]      = !(v && b[64]);
         src_tsrc_rdy_n[i]  = !v;
      end
      trn_tdst_rdy_n = sink_n;
      trn_lnk_up_n   = lnk_n;
      trn_tbuf_av    = tbuf;
   endtask

   task automatic scoreboard();
      logic [2:0] elig;
      logic [2:0] exp_rdy;
      logic [65:0] b;
      int cls [3];
      cls[0] = 2; cls[1] = 0; cls[2] = 1;
      if (!m_busy) begin
         chk("sb_idle_vld", trn_tsrc_rdy_n, 1'b1);
         chk("sb_idle_rdy", src_tdst_rdy_n, 3'b111);
         for (int i = 0; i < 3; i++)
            elig[i] = src_valid(i) && mem[i][rd[i]][65] && !trn_lnk_up_n && trn_tbuf_av[cls[i]];
         if (elig != 3'b000) begin
            m_busy = 1'b1;
            if (TbPrio != 0 && elig[0]) m_g = 0;
            else if (elig[m_rr]) m_g = m_rr;
            else if (elig[(m_rr + 1) % 3]) m_g = (m_rr + 1) % 3;
            else m_g = (m_rr + 2) % 3;
         end
      end else begin
         b = mem[m_g][rd[m_g]];
         chk("sb_vld", trn_tsrc_rdy_n, 1'b0);
         chk("sb_td", trn_td, b[63:0]);
         chk("sb_eof", trn_teof_n, !b[64]);
         exp_rdy = 3'b111;
         exp_rdy[m_g] = trn_tdst_rdy_n;
         chk("sb_rdy", src_tdst_rdy_n, exp_rdy);
         if (!trn_tdst_rdy_n && b[64]) begin
            m_busy = 1'b0;
            m_rr = (m_g + 1) % 3;
         end
      end
   endtask

   // One clock: apply accepted beats and knobs after the edge, sample on the falling edge.
   task automatic tick();
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (acc[i]) begin
            if (mem[i][rd[i]][64]) exp_pkt[i]++;
            rd[i]++;
         end
      end
      drive();
      @(negedge sys_clk);
      cyc++;
      for (int i = 0; i < 3; i++) acc[i] = src_valid(i) && !src_tdst_rdy_n[i];
      if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n && !trn_tsof_n) begin
         sof_src.push_back(int'(trn_td[63:56]));
         sof_cyc.push_back(cyc);
      end
      if (sb_en) scoreboard();
   endtask

   task automatic wait_idle(input string tag, input int bound);
      bit done;
      done = 1'b0;
      for (int t = 0; t < bound && !done; t++) begin
         tick();
         done = (rd[0] == wr[0]) && (rd[1] == wr[1]) && (rd[2] == wr[2]) && trn_tsrc_rdy_n;
      end
      chk(tag, done, 1'b1);
   endtask

   task automatic check_order(input string tag, input int exp [$]);
      chk({tag, "_cnt"}, sof_src.size(), exp.size());
      for (int k = 0; k < sof_src.size() && k < exp.size(); k++)
         chk({tag, "_src"}, sof_src[k], exp[k]);
   endtask

`ifdef HM_TX_ARB_STATS_EN
   task automatic check_stats(input string tag);
      for (int i = 0; i < 3; i++) chk({tag, "_pkt"}, stat_pkt[16*i +: 16], 16'(exp_pkt[i]));
      chk({tag, "_abort"}, stat_abort, 8'(exp_abort));
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int nb;
      int stall;
      bit seen;
      int q [$];
      for (int i = 0; i < 3; i++) begin
         flush(i);
         exp_pkt[i] = 0;
      end
      drive();
      tick();
      tick();
      chk("rst_vld", trn_tsrc_rdy_n, 1'b1);
      chk("rst_td", trn_td, 64'h0);
      chk("rst_ctl", {trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n, trn_trem_n}, {3'b111, 8'h00});
      chk("rst_rdy", src_tdst_rdy_n, 3'b111);
      chk("rst_abort", src_abort, 3'b000);
      sys_rst = 1'b0;
      lnk_n = 1'b0;
      tbuf = 6'h3f;
      sink_n = 1'b0;
      tick();

      // Two-beat read from src1 with one-cycle grant latency.
      push_beat(1, 1, 0, 64'h0000000100000001);
      push_beat(1, 0, 1, 64'hcacaca00_00000000);
      tick();
      chk("t1_lat", trn_tsrc_rdy_n, 1'b1);
      tick();
      chk("t1_b1_vld", trn_tsrc_rdy_n, 1'b0);
      chk("t1_b1_td", trn_td, 64'h0000000100000001);
      chk("t1_b1_ctl", {trn_tsof_n, trn_teof_n}, 2'b01);
      chk("t1_b1_rdy", src_tdst_rdy_n, 3'b101);
      tick();
      chk("t1_b2_td", trn_td, 64'hcacaca00_00000000);
      chk("t1_b2_ctl", {trn_tsof_n, trn_teof_n}, 2'b10);
      chk("t1_b2_rdy", src_tdst_rdy_n, 3'b101);
      tick();
      chk("t1_done", {trn_tsrc_rdy_n, src_tdst_rdy_n}, 4'b1111);

      // src1/src2 alternate, one idle cycle between packets.
      sof_src.delete();
      sof_cyc.delete();
      push_pkt(1, 3, {8'd1, 56'h100});
      push_pkt(1, 3, {8'd1, 56'h200});
      tick();
      push_pkt(2, 3, {8'd2, 56'h100});
      push_pkt(2, 3, {8'd2, 56'h200});
      wait_idle("t2_drain", 60);
      q = '{1, 2, 1, 2};
      check_order("t2", q);
      for (int k = 0; k + 1 < sof_cyc.size(); k++) chk("t2_gap", sof_cyc[k+1] - sof_cyc[k], 4);

      // Completion priority, then completion class blocked by tbuf_av.
      sof_src.delete();
      push_pkt(0, 2, {8'd0, 56'h300});
      push_pkt(0, 2, {8'd0, 56'h400});
      push_pkt(1, 2, {8'd1, 56'h300});
      wait_idle("t3a_drain", 60);
      q = '{0, 0, 1};
      check_order("t3a", q);
      sof_src.delete();
      tbuf = 6'h3b;
      push_pkt(0, 2, {8'd0, 56'h500});
      push_pkt(1, 2, {8'd1, 56'h500});
      tick();
      tick();
      tick();
      tbuf = 6'h3f;
      wait_idle("t3b_drain", 60);
      q = '{1, 0};
      check_order("t3b", q);

      // Sink ready toggling during a 4-beat posted write.
      push_pkt(2, 4, 64'hcafebabe_deadc0de);
      nb = 0;
      sink_n = 1'b0;
      for (int t = 0; t < 30 && nb < 4; t++) begin
         sink_n = ~sink_n;
         tick();
         if (!trn_tsrc_rdy_n) begin
            chk("t4_td", trn_td, 64'hcafebabe_deadc0de + 64'(nb));
            if (!trn_tdst_rdy_n) nb++;
         end
      end
      chk("t4_beats", nb, 4);
      sink_n = 1'b0;
      tick();
      chk("t4_nodup", trn_tsrc_rdy_n, 1'b1);

      // Source stalls after beat 1: watchdog discontinues after 8 idle cycles.
      gag_at[2] = 1;
      push_pkt(2, 3, {8'd2, 56'h700});
      gag_at[2] = 1;
      seen = 1'b0;
      stall = -1;
      for (int t = 0; t < 40 && !seen; t++) begin
         tick();
         if (stall < 0) begin
            if (!trn_tsrc_rdy_n && !trn_tsof_n) stall = 0;
         end else if (trn_tsrc_dsc_n) begin
            stall++;
         end else begin
            seen = 1'b1;
            chk("t5_dsc_ctl", {trn_tsrc_rdy_n, trn_teof_n, trn_tsof_n}, 3'b001);
            chk("t5_dsc_rdy", src_tdst_rdy_n, 3'b111);
         end
      end
      chk("t5_dsc_seen", seen, 1'b1);
      chk("t5_stall", stall, 8);
      tick();
      exp_abort++;
      chk("t5_abort", src_abort, 3'b100);
      chk("t5_idle", trn_tsrc_rdy_n, 1'b1);
      flush(2);
      tick();
      chk("t5_abort_clr", src_abort, 3'b000);

      // Link drops on beat 2 of a completion.
      push_pkt(0, 3, {8'd0, 56'h600});
      tick();
      tick();
      chk("t6_b1", trn_tsrc_rdy_n, 1'b0);
      lnk_n = 1'b1;
      tick();
      chk("t6_vld_off", trn_tsrc_rdy_n, 1'b1);
      chk("t6_rdy_off", src_tdst_rdy_n, 3'b111);
      chk("t6_no_abort_yet", src_abort, 3'b000);
      lnk_n = 1'b0;
      tick();
      exp_abort++;
      chk("t6_abort", src_abort, 3'b001);
      flush(0);
      tick();
      chk("t6_abort_clr", src_abort, 3'b000);
`ifdef HM_TX_ARB_STATS_EN
      check_stats("t6_stat");
`endif

      // Randomized traffic against the packet-level model.
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) exp_pkt[i] = 0;
      exp_abort = 0;
      m_busy = 1'b0;
      m_rr = 0;
      sb_en = 1'b1;
      nb = 0;
      for (int t = 0; t < 1500; t++) begin
         tick();
         if (nb < 3 && ($urandom % 4 == 0)) begin
            sink_n = 1'b1;
            nb++;
         end else begin
            sink_n = 1'b0;
            nb = 0;
         end
         tbuf = {3'($urandom), ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0};
         for (int i = 0; i < 3; i++)
            if (rd[i] == wr[i] && ($urandom % 3 == 0))
               push_pkt(i, 1 + int'($urandom % 4), {32'($urandom), 32'($urandom)});
      end
      sink_n = 1'b0;
      tbuf = 6'h3f;
      wait_idle("rnd_drain", 200);
      sb_en = 1'b0;
`ifdef HM_TX_ARB_STATS_EN
      check_stats("rnd_stat");
`endif

      // Reset in the middle of a packet.
      push_pkt(1, 4, {8'd1, 56'h900});
      tick();
      tick();
      chk("t7_b1", trn_tsrc_rdy_n, 1'b0);
      sys_rst = 1'b1;
      acc = '0;
      #1;
      chk("t7_rst_vld", trn_tsrc_rdy_n, 1'b1);
      chk("t7_rst_rdy", src_tdst_rdy_n, 3'b111);
      tick();
      sys_rst = 1'b0;
      flush(1);
      for (int i = 0; i < 3; i++) exp_pkt[i] = 0;
      exp_abort = 0;
      tick();
      chk("t7_no_abort", src_abort, 3'b000);
      tick();
      chk("t7_idle", {trn_tsrc_rdy_n, src_abort}, 4'b1000);
`ifdef HM_TX_ARB_STATS_EN
      check_stats("t7_stat");
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
